// File: rtl/div_clk_sched.sv
// div_clk_sched: NCH-channel 50% duty clock divider with run-time retune over a valid/ready config port; outputs registered.
// New ratios wait for the target channel's half-period boundary (oCfgRdy low meanwhile); `DIV_PRESCALE_EN adds a shared PRE prescaler.
module div_clk_sched #(
   parameter int NCH     = 4,
   parameter int CW      = 16,
   parameter int CHW     = 2,
   parameter int DEF_DIV = 49,
   parameter int PRE     = 10
) (
   input  logic           iClk_in,
   input  logic           iRst,
   input  logic [NCH-1:0] iEn,
   input  logic           iCfgVld,
   output logic           oCfgRdy,
   input  logic [CHW-1:0] iCfgCh,
   input  logic [CW-1:0]  iCfgDiv,
   output logic [NCH-1:0] oDivClk,
   output logic [NCH-1:0] oTick,
   output logic           oPend
);

   typedef enum logic {sIdle, sWait} cfgState_t;

   cfgState_t      state, stateNxt;
   logic [CHW-1:0] pch;
   logic [CW-1:0]  pdiv;
   logic           adv;
   logic           applyNow;
   logic           chInRange;
   logic [NCH-1:0] termHit;
   logic [NCH-1:0] selHit;

   if (NCH < 1 || NCH > 8 || (2**CHW) < NCH || PRE < 2 || PRE > 255) begin : gBadParam
      $error("div_clk_sched: illegal parameter combination");
   end

`ifdef DIV_PRESCALE_EN
   logic [7:0] psc;

   always_ff @(posedge iClk_in or negedge iRst) begin
      if (!iRst)                  psc <= '0;
      else if (psc == 8'(PRE-1))  psc <= '0;
      else                        psc <= psc + 8'd1;
   end

   assign adv = (psc == 8'(PRE-1));
`else
   assign adv = 1'b1;
`endif

   for (genvar ch = 0; ch < NCH; ch++) begin : gCh
      logic [CW-1:0] cnt;
      logic [CW-1:0] div;
      logic          clkQ;
      logic          tickQ;

      // >= rather than == so a ratio lowered under a mid-count never lets cnt run past it
      assign termHit[ch] = (cnt >= div);
      assign selHit[ch]  = (pch == CHW'(ch));
      assign oDivClk[ch] = clkQ;
      assign oTick[ch]   = tickQ;

      always_ff @(posedge iClk_in or negedge iRst) begin
         if (!iRst) begin
            cnt   <= '0;
            div   <= CW'(DEF_DIV);
            clkQ  <= 1'b0;
            tickQ <= 1'b0;
         end else begin
            if (adv) begin
               if (!iEn[ch]) begin
                  cnt   <= '0;
                  clkQ  <= 1'b0;
                  tickQ <= 1'b0;
               end else if (termHit[ch]) begin
                  cnt   <= '0;
                  clkQ  <= ~clkQ;
                  tickQ <= 1'b1;
               end else begin
                  cnt   <= cnt + CW'(1);
                  tickQ <= 1'b0;
               end
            end else begin
               tickQ <= 1'b0;
            end
            if (applyNow && selHit[ch]) div <= pdiv;
         end
      end
   end

   assign chInRange = ({1'b0, iCfgCh} < (CHW+1)'(NCH));

   always_ff @(posedge iClk_in or negedge iRst) begin
      if (!iRst) begin
         state <= sIdle;
         pch   <= '0;
         pdiv  <= '0;
      end else begin
         state <= stateNxt;
         if (state == sIdle && iCfgVld) begin
            pch  <= iCfgCh;
            pdiv <= iCfgDiv;
         end
      end
   end

   always_comb begin
      stateNxt = state;
      oCfgRdy  = 1'b0;
      oPend    = 1'b0;
      applyNow = 1'b0;
      case (state)
         sIdle: begin
            oCfgRdy = 1'b1;
            // out-of-range channel requests are accepted and silently dropped
            if (iCfgVld && chInRange) stateNxt = sWait;
         end
         sWait: begin
            oPend    = 1'b1;
            applyNow = |(selHit & (~iEn | (termHit & {NCH{adv}})));
            if (applyNow) stateNxt = sIdle;
         end
         default: stateNxt = sIdle;
      endcase
   end

endmodule

// File: tb/tb_div_clk_sched.sv
// Bench for div_clk_sched: directed scenarios plus random enables/configs checked cycle by cycle against a toggle-schedule model.
module tb_div_clk_sched;
   localparam int NCH     = 4;
   localparam int CW      = 16;
   localparam int CHW     = 3;
   localparam int DEF_DIV = 49;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] en = '0;
   logic           cfgVld = 1'b0;
   logic           cfgRdy;
   logic [CHW-1:0] cfgCh = '0;
   logic [CW-1:0]  cfgDiv = '0;
   logic [NCH-1:0] divClk;
   logic [NCH-1:0] tick;
   logic           pend;

   int checks = 0;
   int errors = 0;

   div_clk_sched #(.NCH(NCH), .CW(CW), .CHW(CHW), .DEF_DIV(DEF_DIV), .PRE(10)) dut (
      .iClk_in(clk), .iRst(rst), .iEn(en),
      .iCfgVld(cfgVld), .oCfgRdy(cfgRdy), .iCfgCh(cfgCh), .iCfgDiv(cfgDiv),
      .oDivClk(divClk), .oTick(tick), .oPend(pend)
   );

   initial forever #5 clk = ~clk;

   // model: each running channel holds the absolute cycle number of its next toggle
   longint         mCyc = 0;
   longint         mDue [NCH];
   int             mDiv [NCH];
   bit             mRun [NCH];
   logic [NCH-1:0] mClk, mTick;
   bit             mPend;
   int             mPch;
   int             mPdiv;
   bit             lastAcc;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int c = 0; c < NCH; c++) begin
         mDiv[c] = DEF_DIV;
         mRun[c] = 1'b0;
         mDue[c] = 0;
      end
      mClk  = '0;
      mTick = '0;
      mPend = 1'b0;
   endtask

   task automatic modelEdge();
      logic [NCH-1:0] tog;
      tog = '0;
      for (int c = 0; c < NCH; c++) begin
         if (!en[c]) begin
            mClk[c]  = 1'b0;
            mTick[c] = 1'b0;
            mRun[c]  = 1'b0;
         end else begin
            if (!mRun[c]) begin
               mRun[c] = 1'b1;
               mDue[c] = mCyc + mDiv[c];
            end
            mTick[c] = (mDue[c] == mCyc);
            if (mTick[c]) begin
               tog[c]  = 1'b1;
               mClk[c] = ~mClk[c];
            end
         end
      end
      if (mPend) begin
         if (!en[mPch] || tog[mPch]) begin
            mDiv[mPch] = mPdiv;
            mPend      = 1'b0;
         end
      end else if (cfgVld && int'(cfgCh) < NCH) begin
         mPend = 1'b1;
         mPch  = int'(cfgCh);
         mPdiv = int'(cfgDiv);
      end
      for (int c = 0; c < NCH; c++)
         if (tog[c]) mDue[c] = mCyc + mDiv[c] + 1;
      mCyc++;
   endtask

   task automatic step();
      @(posedge clk);
      lastAcc = cfgVld && !mPend;
      modelEdge();
      #1;
      checkVal("divClk", 32'(divClk), 32'(mClk));
      checkVal("tick",   32'(tick),   32'(mTick));
      checkVal("cfgRdy", 32'(cfgRdy), 32'(!mPend));
      checkVal("pend",   32'(pend),   32'(mPend));
   endtask

   task automatic doReset();
      rst = 1'b0;
      #2;
      checkVal("rstDivClk", 32'(divClk), 32'd0);
      checkVal("rstTick",   32'(tick),   32'd0);
      checkVal("rstRdy",    32'(cfgRdy), 32'd1);
      checkVal("rstPend",   32'(pend),   32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      modelReset();
   endtask

   initial begin
      int cntA;
      bit seen;
      modelReset();
      #1;
      doReset();

      // default divide-by-100 on ch0: toggles at enabled edges 50,100,150,200
      en = 4'b0001;
      cntA = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         cntA += int'(tick[0]);
      end
      checkVal("defTicks", 32'(cntA), 32'd4);
      checkVal("idleCh", 32'(divClk[3:1]), 32'd0);

      // retune ch0 to 9 when cnt=20: waits 29 cycles for the boundary
      doReset();
      for (int i = 0; i < 20; i++) step();
      cfgVld = 1'b1; cfgCh = 3'd0; cfgDiv = 16'd9;
      step();
      cfgVld = 1'b0;
      cntA = int'(pend);
      for (int i = 0; i < 200 && pend; i++) begin
         step();
         cntA += int'(pend);
      end
      checkVal("retunePend", 32'(cntA), 32'd29);
      for (int i = 0; i < 60; i++) step();

      // disabled ch2 applies on the very next edge
      cfgVld = 1'b1; cfgCh = 3'd2; cfgDiv = 16'd3;
      step();
      cfgVld = 1'b0;
      cntA = int'(pend);
      for (int i = 0; i < 2; i++) begin
         step();
         cntA += int'(pend);
      end
      checkVal("disPend", 32'(cntA), 32'd1);
      en[2] = 1'b1;
      cntA = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         cntA += int'(tick[2]);
      end
      checkVal("div3Ticks", 32'(cntA), 32'd10);

      // div=0 toggles every clock
      cfgVld = 1'b1; cfgCh = 3'd1; cfgDiv = 16'd0;
      step();
      cfgVld = 1'b0;
      step();
      en[1] = 1'b1;
      cntA = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         cntA += int'(tick[1]);
      end
      checkVal("div0Ticks", 32'(cntA), 32'd10);

      // out-of-range channel: accepted, never pending
      cfgVld = 1'b1; cfgCh = 3'd5; cfgDiv = 16'd7;
      step();
      checkVal("oorPend", 32'(pend), 32'd0);
      checkVal("oorRdy", 32'(cfgRdy), 32'd1);
      cfgVld = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // reset while a ch0 retune is pending discards it
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         seen = tick[0];
      end
      checkVal("tickSeen", 32'(seen), 32'd1);
      cfgVld = 1'b1; cfgCh = 3'd0; cfgDiv = 16'd30;
      step();
      cfgVld = 1'b0;
      checkVal("midPend", 32'(pend), 32'd1);
      doReset();
      cntA = 0;
      for (int i = 0; i < 120; i++) begin
         step();
         cntA += int'(tick[0]);
      end
      checkVal("postRstTicks", 32'(cntA), 32'd2);

      // random enables and config traffic
      for (int i = 0; i < 4000; i++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 63) == 0) en[c] = ~en[c];
         if (!cfgVld && $urandom_range(0, 5) == 0) begin
            cfgVld = 1'b1;
            cfgCh  = CHW'($urandom_range(0, 5));
            cfgDiv = CW'($urandom_range(0, 12));
         end
         step();
         if (lastAcc) cfgVld = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
